// File: rtl/rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// rpn_stack_ctrl
// Command sequencer for the calculator's operand stack. Takes one RPN command at
// a time from the key/UART decoder and expands it into single push/pop/replace
// strobes. Stack depth is validated at accept, so the stack never sees an
// illegal request.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE with stk_vld)
//   cmd_op[2:0], cmd_num[31:0] opcode (PUSH,POP,ADD,SUB,MUL,DUP,SWAP,NEG), operand
//   done                       1-cycle pulse when a command finishes
//   err[1:0]                   0 ok, 1 underflow, 2 overflow, 3 stack fault;
//                              held until the next accept
//   busy                       high whenever not in IDLE
//   stk_push/pop/replace       one-hot 1-cycle stack strobes
//   stk_data[31:0]             data for push/replace
//   stk_size, stk_top          current stack depth and top entry
//   stk_error, stk_vld         stack fault flag; stack idle and may take an op
// -----------------------------------------------------------------------------
module rpn_stack_ctrl #(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_num,
    output logic        done,
    output logic [1:0]  err,
    output logic        busy,
    output logic        stk_push,
    output logic        stk_pop,
    output logic        stk_replace,
    output logic [31:0] stk_data,
    input  logic [9:0]  stk_size,
    input  logic [31:0] stk_top,
    input  logic        stk_error,
    input  logic        stk_vld
);

    localparam logic [9:0] DEPTH_W = 10'(DEPTH);

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0, OP_POP  = 3'd1, OP_ADD  = 3'd2, OP_SUB = 3'd3,
        OP_MUL  = 3'd4, OP_DUP  = 3'd5, OP_SWAP = 3'd6, OP_NEG = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE, S_POP, W_POP, S_WR, W_WR, S_PUSH2, W_PUSH2, DONE
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_FAULT = 2'd3;

    state_t      state_q, state_d;
    op_t         op_q,    op_d;
    logic [31:0] a_q,     a_d;     // top at accept
    logic [31:0] b_q,     b_d;     // second operand, read after the first pop
    logic [31:0] n_q,     n_d;     // PUSH operand
    logic [1:0]  err_q,   err_d;

    // Depth check for the incoming command; ERR_OK means it may proceed.
    logic [1:0]  chk_err;
    logic        two_operand;

    always_comb begin
        chk_err     = ERR_OK;
        two_operand = 1'b0;
        case (op_t'(cmd_op))
            OP_PUSH: if (stk_size >= DEPTH_W) chk_err = ERR_OVER;
            OP_POP,
            OP_NEG:  if (stk_size == 10'd0)   chk_err = ERR_UNDER;
            OP_DUP: begin
                if (stk_size == 10'd0)          chk_err = ERR_UNDER;
                else if (stk_size >= DEPTH_W)   chk_err = ERR_OVER;
            end
            default: begin  // ADD, SUB, MUL, SWAP
                two_operand = 1'b1;
                if (stk_size < 10'd2) chk_err = ERR_UNDER;
            end
        endcase
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        n_d         = n_q;
        err_d       = err_q;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_replace = 1'b0;
        stk_data    = 32'd0;

        case (state_q)
            IDLE: begin
                cmd_ready = stk_vld;
                if (cmd_valid && stk_vld) begin
                    op_d = op_t'(cmd_op);
                    a_d  = stk_top;
                    n_d  = cmd_num;
                    if (chk_err != ERR_OK) begin
                        err_d   = chk_err;
                        state_d = DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = two_operand ? S_POP : S_WR;
                    end
                end
            end
            S_POP: begin
                stk_pop = 1'b1;
                state_d = W_POP;
            end
            W_POP: begin
                if (stk_vld) begin
                    b_d = stk_top;
                    if (stk_error) begin
                        err_d   = ERR_FAULT;
                        state_d = DONE;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                state_d = W_WR;
                case (op_q)
                    OP_PUSH: begin stk_push    = 1'b1; stk_data = n_q;          end
                    OP_POP:  begin stk_pop     = 1'b1;                          end
                    OP_DUP:  begin stk_push    = 1'b1; stk_data = a_q;          end
                    OP_NEG:  begin stk_replace = 1'b1; stk_data = 32'd0 - a_q;  end
                    OP_ADD:  begin stk_replace = 1'b1; stk_data = b_q + a_q;    end
                    OP_SUB:  begin stk_replace = 1'b1; stk_data = b_q - a_q;    end
                    OP_MUL:  begin stk_replace = 1'b1; stk_data = b_q * a_q;    end
                    default: begin stk_replace = 1'b1; stk_data = a_q;          end // SWAP
                endcase
            end
            W_WR: begin
                if (stk_vld) begin
                    if (stk_error) begin
                        err_d   = ERR_FAULT;
                        state_d = DONE;
                    end else begin
                        state_d = (op_q == OP_SWAP) ? S_PUSH2 : DONE;
                    end
                end
            end
            S_PUSH2: begin
                // Second half of SWAP: the old second entry goes back on top.
                stk_push = 1'b1;
                stk_data = b_q;
                state_d  = W_PUSH2;
            end
            W_PUSH2: begin
                if (stk_vld) begin
                    if (stk_error) err_d = ERR_FAULT;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values computed for this cycle, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_PUSH;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            n_q     <= 32'd0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_ctrl
// Directed bench for rpn_stack_ctrl. A behavioural 512-entry stack answers the
// controller's strobes: each accepted op makes the stack busy for one cycle,
// except a pop that empties it. A fault input can be forced onto stk_error.
// -----------------------------------------------------------------------------
module tb_rpn_stack_ctrl;

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           MUL  = 3'd4, DUP = 3'd5, SWAP = 3'd6, NEG = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_num;
    logic        done;
    logic [1:0]  err;
    logic        busy;
    logic        stk_push, stk_pop, stk_replace;
    logic [31:0] stk_data;
    logic [9:0]  stk_size;
    logic [31:0] stk_top;
    logic        stk_error;
    logic        stk_vld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rpn_stack_ctrl #(.DEPTH(512)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_num(cmd_num),
        .done(done), .err(err), .busy(busy),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_replace(stk_replace),
        .stk_data(stk_data), .stk_size(stk_size), .stk_top(stk_top),
        .stk_error(stk_error), .stk_vld(stk_vld)
    );

    // ---------------- behavioural stack ----------------
    logic [31:0] mem [512];
    int          m_size;
    logic        m_busy;
    logic        m_err;      // set if the stack ever sees an illegal request
    logic        fault_inj;
    int          strobe_cnt;
    int          onehot_bad;
    int          done_cnt;

    assign stk_size  = 10'(m_size);
    assign stk_top   = (m_size > 0) ? mem[m_size-1] : 32'd0;
    assign stk_vld   = ~m_busy;
    assign stk_error = m_err | fault_inj;

    always @(posedge clk) begin
        if (reset) begin
            m_size <= 0;
            m_busy <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_busy <= 1'b0;
            if (stk_push) begin
                if (m_size < 512) begin
                    mem[m_size] <= stk_data;
                    m_size      <= m_size + 1;
                    m_busy      <= 1'b1;
                end else m_err <= 1'b1;
            end else if (stk_pop) begin
                if (m_size > 0) begin
                    m_size <= m_size - 1;
                    m_busy <= (m_size > 1);
                end else m_err <= 1'b1;
            end else if (stk_replace) begin
                if (m_size > 0) begin
                    mem[m_size-1] <= stk_data;
                    m_busy        <= 1'b1;
                end else m_err <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (stk_push | stk_pop | stk_replace) strobe_cnt++;
        if ((32'(stk_push) + 32'(stk_pop) + 32'(stk_replace)) > 1) onehot_bad++;
        if (done) done_cnt++;
    end

    // ---------------- command driver ----------------
    // Called #1 after a rising edge; returns #1 after the edge on which done
    // became visible. lat = rising edges after the accept edge until done.
    task automatic send(input logic [2:0] op, input logic [31:0] num, output int lat);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_num = num;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: op %0d got no done, required done within 40 cycles", op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_num = 32'd0; fault_inj = 1'b0;
        strobe_cnt = 0; onehot_bad = 0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, err} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: busy/done/err got %b required 0000", {busy, done, err}); end
        checks++; if ({stk_push, stk_pop, stk_replace, stk_data} !== 35'd0) begin errors++;
            $display("FAIL reset_strobes: strobes %b data %h required all 0", {stk_push, stk_pop, stk_replace}, stk_data); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: cmd_ready got %b required 1", cmd_ready); end
    endtask

    task automatic test_push_add();
        int lat;
        send(PUSH, 32'd5, lat);
        checks++; if (lat != 3 || err !== 2'd0) begin errors++;
            $display("FAIL push_latency: lat %0d err %0d required 3 / 0", lat, err); end
        send(PUSH, 32'd7, lat);
        send(ADD, 32'd0, lat);
        checks++; if (lat != 6) begin errors++;
            $display("FAIL add_latency: got %0d required 6", lat); end
        checks++; if (stk_top !== 32'd12 || stk_size !== 10'd1 || err !== 2'd0) begin errors++;
            $display("FAIL add_result: top %h size %0d err %0d required 0000000c / 1 / 0", stk_top, stk_size, err); end
        send(POP, 32'd0, lat);
        checks++; if (lat != 2 || stk_size !== 10'd0) begin errors++;
            $display("FAIL pop_last_latency: lat %0d size %0d required 2 / 0", lat, stk_size); end
    endtask

    task automatic test_sub_mul();
        int lat;
        send(PUSH, 32'd3, lat);
        send(PUSH, 32'd10, lat);
        send(SUB, 32'd0, lat);
        checks++; if (stk_top !== 32'hFFFF_FFF9 || stk_size !== 10'd1) begin errors++;
            $display("FAIL sub_wrap: top %h size %0d required fffffff9 / 1", stk_top, stk_size); end
        send(POP, 32'd0, lat);
        send(PUSH, 32'h0001_0000, lat);
        send(PUSH, 32'h0001_0000, lat);
        send(MUL, 32'd0, lat);
        checks++; if (stk_top !== 32'd0 || stk_size !== 10'd1 || lat != 6) begin errors++;
            $display("FAIL mul_wrap: top %h size %0d lat %0d required 00000000 / 1 / 6", stk_top, stk_size, lat); end
        send(PUSH, 32'd6, lat);
        send(MUL, 32'd0, lat);
        checks++; if (stk_top !== 32'd0 || stk_size !== 10'd1) begin errors++;
            $display("FAIL mul_zero: top %h size %0d required 00000000 / 1", stk_top, stk_size); end
        send(PUSH, 32'd6, lat);
        send(PUSH, 32'd7, lat);
        send(MUL, 32'd0, lat);
        checks++; if (stk_top !== 32'd42 || stk_size !== 10'd2) begin errors++;
            $display("FAIL mul_small: top %h size %0d required 0000002a / 2", stk_top, stk_size); end
        send(POP, 32'd0, lat);
        send(POP, 32'd0, lat);
    endtask

    task automatic test_underflow();
        int lat, s0;
        s0 = strobe_cnt;
        send(POP, 32'd0, lat);
        checks++; if (err !== 2'd1 || lat != 0 || strobe_cnt != s0) begin errors++;
            $display("FAIL empty_pop: err %0d lat %0d strobes %0d required 1 / 0 / 0", err, lat, strobe_cnt - s0); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err !== 2'd1) begin errors++;
            $display("FAIL err_hold: err %0d required 1 held until next accept", err); end
        send(DUP, 32'd0, lat);
        checks++; if (err !== 2'd1 || stk_size !== 10'd0) begin errors++;
            $display("FAIL empty_dup: err %0d size %0d required 1 / 0", err, stk_size); end
        send(PUSH, 32'd9, lat);
        checks++; if (err !== 2'd0) begin errors++;
            $display("FAIL err_clear: err %0d required 0 after good accept", err); end
        s0 = strobe_cnt;
        send(ADD, 32'd0, lat);
        checks++; if (err !== 2'd1 || stk_size !== 10'd1 || strobe_cnt != s0) begin errors++;
            $display("FAIL add_size1: err %0d size %0d strobes %0d required 1 / 1 / 0", err, stk_size, strobe_cnt - s0); end
        send(POP, 32'd0, lat);
    endtask

    task automatic test_swap_neg_dup();
        int lat;
        send(PUSH, 32'd1, lat);
        send(PUSH, 32'd2, lat);
        send(SWAP, 32'd0, lat);
        checks++; if (stk_top !== 32'd1 || stk_size !== 10'd2 || err !== 2'd0) begin errors++;
            $display("FAIL swap_top: top %h size %0d err %0d required 00000001 / 2 / 0", stk_top, stk_size, err); end
        send(POP, 32'd0, lat);
        checks++; if (stk_top !== 32'd2 || lat != 3) begin errors++;
            $display("FAIL swap_next: top %h lat %0d required 00000002 / 3", stk_top, lat); end
        send(POP, 32'd0, lat);
        send(PUSH, 32'd1, lat);
        send(NEG, 32'd0, lat);
        checks++; if (stk_top !== 32'hFFFF_FFFF || stk_size !== 10'd1 || lat != 3) begin errors++;
            $display("FAIL neg: top %h size %0d lat %0d required ffffffff / 1 / 3", stk_top, stk_size, lat); end
        send(DUP, 32'd0, lat);
        checks++; if (stk_top !== 32'hFFFF_FFFF || stk_size !== 10'd2) begin errors++;
            $display("FAIL dup: top %h size %0d required ffffffff / 2", stk_top, stk_size); end
        send(POP, 32'd0, lat);
        send(POP, 32'd0, lat);
    endtask

    task automatic test_fault();
        int lat;
        fault_inj = 1'b1;
        send(PUSH, 32'h55, lat);
        fault_inj = 1'b0;
        checks++; if (err !== 2'd3) begin errors++;
            $display("FAIL stack_fault: err %0d required 3", err); end
        send(POP, 32'd0, lat);
        checks++; if (err !== 2'd0 || stk_size !== 10'd0) begin errors++;
            $display("FAIL after_fault: err %0d size %0d required 0 / 0", err, stk_size); end
    endtask

    task automatic test_back_to_back();
        int cyc, n, bad_err, lat;
        int at [3];
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = PUSH; cmd_num = 32'hAB;
        cyc = 0; n = 0; bad_err = 0;
        while (n < 3 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (done) begin
                at[n] = cyc;
                if (err !== 2'd0) bad_err++;
                n++;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (n != 3 || bad_err != 0 || stk_size !== 10'd3) begin errors++;
            $display("FAIL b2b_count: dones %0d bad_err %0d size %0d required 3 / 0 / 3", n, bad_err, stk_size); end
        else begin
            checks++; if (at[1] - at[0] != 5 || at[2] - at[1] != 5) begin errors++;
                $display("FAIL b2b_spacing: gaps %0d %0d required 5 5", at[1] - at[0], at[2] - at[1]); end
        end
        repeat (3) send(POP, 32'd0, lat);
    endtask

    task automatic test_overflow();
        int lat, bad, s0;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            send(PUSH, 32'(i), lat);
            if (err !== 2'd0) bad++;
        end
        checks++; if (bad != 0 || stk_size !== 10'd512 || stk_top !== 32'd511) begin errors++;
            $display("FAIL fill: bad %0d size %0d top %h required 0 / 512 / 000001ff", bad, stk_size, stk_top); end
        s0 = strobe_cnt;
        send(PUSH, 32'hDEAD, lat);
        checks++; if (err !== 2'd2 || stk_size !== 10'd512 || strobe_cnt != s0 || lat != 0) begin errors++;
            $display("FAIL push_full: err %0d size %0d strobes %0d lat %0d required 2 / 512 / 0 / 0", err, stk_size, strobe_cnt - s0, lat); end
        send(DUP, 32'd0, lat);
        checks++; if (err !== 2'd2 || stk_size !== 10'd512) begin errors++;
            $display("FAIL dup_full: err %0d size %0d required 2 / 512", err, stk_size); end
        send(POP, 32'd0, lat);
        checks++; if (err !== 2'd0 || stk_size !== 10'd511 || stk_top !== 32'd510) begin errors++;
            $display("FAIL pop_full: err %0d size %0d top %h required 0 / 511 / 000001fe", err, stk_size, stk_top); end
    endtask

    task automatic test_reset_mid_add();
        int w, s0, d0;
        w = 0;
        while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
        cmd_valid = 1'b1; cmd_op = ADD; cmd_num = 32'd0;
        @(posedge clk); #1;                     // accept: now S_POP
        cmd_valid = 1'b0;
        @(posedge clk); #1;                     // now W_POP, stack busy
        checks++; if (busy !== 1'b1 || stk_vld !== 1'b0) begin errors++;
            $display("FAIL mid_add_setup: busy %b stk_vld %b required 1 / 0", busy, stk_vld); end
        reset = 1'b1;
        s0 = strobe_cnt; d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({busy, done, err, stk_push, stk_pop, stk_replace} !== 7'd0 || stk_data !== 32'd0) begin errors++;
            $display("FAIL reset_abort: busy %b done %b err %0d strobes %b data %h required all 0",
                     busy, done, err, {stk_push, stk_pop, stk_replace}, stk_data); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (strobe_cnt != s0 || done_cnt != d0) begin errors++;
            $display("FAIL reset_quiet: strobes %0d dones %0d after reset required 0 / 0", strobe_cnt - s0, done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_push_add();
        test_sub_mul();
        test_underflow();
        test_swap_neg_dup();
        test_fault();
        test_back_to_back();
        test_overflow();
        test_reset_mid_add();
        checks++; if (onehot_bad != 0 || m_err !== 1'b0) begin errors++;
            $display("FAIL stack_protocol: multi-strobe cycles %0d illegal ops %b required 0 / 0", onehot_bad, m_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
